// File: rtl/pulse_seq_multi.sv
// Multi-channel pulse sequencer: a shared period counter drives NCH delay/width
// comparators; registers are written to shadow copies and loaded at period boundaries.

module pulse_seq_lane #(
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_dly_i,
  input  logic          wr_wid_i,
  input  logic [CW-1:0] wr_data_i,
  input  logic          load_i,
  input  logic          run_i,
  input  logic [CW-1:0] cnt_i,
  output logic          pulse_o
);
  logic [CW-1:0] dly_sh_q, wid_sh_q, dly_q, wid_q;
  logic [CW:0]   end_w;
  logic          hit_w;

  // One extra bit keeps delay+width from wrapping below delay.
  assign end_w = {1'b0, dly_q} + {1'b0, wid_q};
  assign hit_w = ({1'b0, cnt_i} >= {1'b0, dly_q}) && ({1'b0, cnt_i} < end_w);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_sh_q <= '0;
      wid_sh_q <= '0;
      dly_q    <= '0;
      wid_q    <= '0;
      pulse_o  <= 1'b0;
    end else begin
      if (wr_dly_i) dly_sh_q <= wr_data_i;
      if (wr_wid_i) wid_sh_q <= wr_data_i;
      if (load_i) begin
        dly_q <= dly_sh_q;
        wid_q <= wid_sh_q;
      end
      pulse_o <= run_i && hit_w;
    end
  end
endmodule

module pulse_seq_multi #(
  parameter int NCH      = 4,
  parameter int CW       = 32,
  parameter int SYNC_LEN = 4,
  parameter int AW       = 4
) (
  input  logic           clk_pll,
  input  logic           resetn,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [CW-1:0]  wr_data,
  input  logic           start,
  input  logic           stop,
  output logic [NCH-1:0] Pulse,
  output logic           Sync,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  period_cnt
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, period_cnt_q;
  logic [CW-1:0] per_sh_q, nrep_sh_q, per_q, nrep_q;
  logic          sync_q, busy_q, done_q;

  logic wr_per, wr_nrep, start_ok, last, fin, load, run_out;

  assign wr_per   = wr_en && (wr_addr == AW'(0));
  assign wr_nrep  = wr_en && (wr_addr == AW'(1));
  assign start_ok = (state_q == IDLE) && start && !stop && (per_sh_q >= CW'(2));
  assign last     = (state_q == RUN) && (cnt_q == per_q - CW'(1));
  assign fin      = last && (nrep_q != '0) && ((period_cnt_q + CW'(1)) == nrep_q);
  assign load     = start_ok || last;
  // A stop blanks the outputs on the very next cycle.
  assign run_out  = (state_q == RUN) && !stop;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    localparam logic [AW-1:0] A_DLY = AW'(2 + 2 * k);
    localparam logic [AW-1:0] A_WID = AW'(3 + 2 * k);
    pulse_seq_lane #(.CW(CW)) u_lane (
      .clk_i     (clk_pll),
      .rst_i     (resetn),
      .wr_dly_i  (wr_en && (wr_addr == A_DLY)),
      .wr_wid_i  (wr_en && (wr_addr == A_WID)),
      .wr_data_i (wr_data),
      .load_i    (load),
      .run_i     (run_out),
      .cnt_i     (cnt_q),
      .pulse_o   (Pulse[k])
    );
  end

  always_ff @(posedge clk_pll) begin
    if (resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_cnt_q <= '0;
      per_sh_q     <= '0;
      nrep_sh_q    <= '0;
      per_q        <= '0;
      nrep_q       <= '0;
      sync_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (wr_per)  per_sh_q  <= wr_data;
      if (wr_nrep) nrep_sh_q <= wr_data;
      if (load) begin
        per_q  <= per_sh_q;
        nrep_q <= nrep_sh_q;
      end
      done_q <= 1'b0;
      sync_q <= run_out && (cnt_q < CW'(SYNC_LEN)) && (cnt_q < per_q);
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            period_cnt_q <= '0;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (last) begin
            cnt_q        <= '0;
            period_cnt_q <= period_cnt_q + CW'(1);
            if (fin) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Sync       = sync_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign period_cnt = period_cnt_q;
endmodule

// File: tb/tb_pulse_seq_multi.sv
// Directed bench for pulse_seq_multi; expected output snapshots are queued per
// cycle by the stimulus and compared by an independent monitor.

module tb_pulse_seq_multi;
  logic        clk_pll = 1'b0;
  logic        resetn, wr_en, start, stop;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  Pulse;
  logic        Sync, busy, done;
  logic [31:0] period_cnt;

  pulse_seq_multi #(.NCH(4), .CW(32), .SYNC_LEN(4), .AW(4)) dut (
    .clk_pll    (clk_pll),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .Pulse      (Pulse),
    .Sync       (Sync),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt)
  );

  always #5 clk_pll = ~clk_pll;

  int cyc = 0;
  always @(posedge clk_pll) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [3:0]  p;
    logic        s, b, d;
    bit          pcc;
    logic [31:0] pc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input int at, input logic [3:0] p, input logic s, input logic b,
                      input logic d, input bit pcc, input logic [31:0] pc, input string nm);
    exp_t e;
    e.at = at; e.p = p; e.s = s; e.b = b; e.d = d; e.pcc = pcc; e.pc = pc; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: compares every queued snapshot in the window it targets.
  always @(negedge clk_pll) begin
    exp_t e;
    while (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL %s: window %0d passed unchecked (now %0d)", e.nm, e.at, cyc);
    end
    while (q.size() > 0 && q[0].at == cyc) begin
      e = q.pop_front();
      checks++;
      if (Pulse !== e.p || Sync !== e.s || busy !== e.b || done !== e.d ||
          (e.pcc && period_cnt !== e.pc)) begin
        errors++;
        $display("FAIL %s @%0d: got Pulse=%b Sync=%b busy=%b done=%b pc=%0d, exp Pulse=%b Sync=%b busy=%b done=%b pc=%0d%s",
                 e.nm, cyc, Pulse, Sync, busy, done, period_cnt,
                 e.p, e.s, e.b, e.d, e.pc, e.pcc ? "" : "(unchecked)");
      end
    end
  end

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic wait_until(input int w);
    while (cyc < w) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c;
    resetn = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
    tick(); tick(); tick();
    push(cyc, 4'b0, 0, 0, 0, 1, 0, "reset_held");
    resetn = 1'b0;
    push(cyc + 1, 4'b0, 0, 0, 0, 1, 0, "reset_released");
    tick(); tick();

    // Two periods of 10, channel 0 at cnt 2..4
    wr(0, 10); wr(1, 2); wr(2, 2); wr(3, 3);
    go(t0);
    push(t0, 4'b0, 0, 1, 0, 1, 0, "t1_entry");
    for (int g = 0; g < 20; g++) begin
      c = g % 10;
      push(t0 + 1 + g, {3'b0, (c >= 2 && c < 5)}, (c < 4), (g < 19), (g == 19), (g == 19), 2, "t1_run");
    end
    push(t0 + 21, 4'b0, 0, 0, 0, 1, 2, "t1_after");
    wait_until(t0 + 23);

    // Channel 1 truncated at end of an 8-cycle period
    wr(0, 8); wr(1, 1); wr(3, 0); wr(4, 6); wr(5, 5);
    go(t0);
    push(t0, 4'b0, 0, 1, 0, 1, 0, "t2_entry");
    for (int g = 0; g < 8; g++)
      push(t0 + 1 + g, {2'b0, (g >= 6), 1'b0}, (g < 4), (g < 7), (g == 7), (g == 7), 1, "t2_trunc");
    push(t0 + 9, 4'b0, 0, 0, 0, 1, 1, "t2_after");
    wait_until(t0 + 10);

    // Endless run; delay change mid-period takes effect next period
    wr(0, 10); wr(1, 0); wr(2, 1); wr(3, 2); wr(5, 0);
    go(t0);
    for (int g = 0; g < 20; g++) begin
      c = g % 10;
      push(t0 + 1 + g, {3'b0, (g < 10) ? (c >= 1 && c < 3) : (c >= 4 && c < 6)},
           (c < 4), 1, 0, (g == 11), 1, "t3_reload");
    end
    wait_until(t0 + 5);
    wr(2, 4);
    wait_until(t0 + 25);
    push(t0 + 25, 4'b0001, 0, 1, 0, 1, 2, "t4_before_stop");
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    push(t0 + 26, 4'b0, 0, 0, 0, 1, 2, "t4_stop");
    push(t0 + 27, 4'b0, 0, 0, 0, 1, 2, "t4_idle");
    wait_until(t0 + 28);

    // Reset in the middle of a pulse, then start with period cleared
    go(t0);
    push(t0 + 5, 4'b0001, 0, 1, 0, 1, 0, "t5_pulse");
    wait_until(t0 + 5);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    push(cyc, 4'b0, 0, 0, 0, 1, 0, "t5_reset");
    go(t0);
    push(t0, 4'b0, 0, 0, 0, 1, 0, "t5_start_p0");
    push(t0 + 1, 4'b0, 0, 0, 0, 1, 0, "t5_start_p0_next");
    wait_until(t0 + 2);

    // period=1 is rejected
    wr(0, 1);
    go(t0);
    push(t0, 4'b0, 0, 0, 0, 1, 0, "t6_per1");
    push(t0 + 1, 4'b0, 0, 0, 0, 1, 0, "t6_per1_next");
    wait_until(t0 + 2);

    // delay+width overflowing CW bits must not assert below delay
    wr(0, 32'hFFFF_FFFF); wr(1, 0); wr(2, 32'hFFFF_FFFE); wr(3, 4);
    go(t0);
    for (int g = 0; g < 6; g++)
      push(t0 + 1 + g, 4'b0, (g < 4), 1, 0, 0, 0, "t7_nowrap");
    wait_until(t0 + 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push(cyc, 4'b0, 0, 0, 0, 0, 0, "t7_stop");
    tick(); tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
